instr_fetch_unit: RTL and testbench

- Fetch stage directly upstream of the opcode decoder/control unit.
- Holds the PC and issues one-outstanding requests to instruction memory with a req/ready + rvalid handshake.
- Buffers returned words in a 2-entry FIFO and presents instruction, PC and opcode field to decode with valid/stall flow control.
- Handles branch redirects, including flushing stale in-flight responses.

---
 rtl/instr_fetch_unit.sv | 127 ++++++++++++
 tb/tb_instr_fetch_unit.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one outstanding imem request at a time,
// buffers returned words in a small FIFO and presents the head to the decoder.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        id_stall,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [5:0]  if_opcode
);

    localparam int unsigned PtrW = $clog2(BUF_DEPTH);
    localparam int unsigned CntW = $clog2(BUF_DEPTH + 1);
    localparam logic [CntW-1:0] Depth = CntW'(BUF_DEPTH);

    typedef enum logic [1:0] {StReq, StWait, StDrop} state_e;

    state_e           r_state;
    logic [31:0]      r_pc;
    logic [31:0]      r_req_pc;
    logic [CntW-1:0]  r_count;
    logic [PtrW-1:0]  r_wr_ptr;
    logic [PtrW-1:0]  r_rd_ptr;
    logic [31:0]      r_buf_instr [BUF_DEPTH];
    logic [31:0]      r_buf_pc    [BUF_DEPTH];

    logic w_has_space;
    logic w_issue;
    logic w_push;
    logic w_pop;
    logic w_unused_tgt_lsb;

    // Handshake decode and combinational presentation of the FIFO head.
    always_comb begin
        w_has_space      = (r_count < Depth);
        w_unused_tgt_lsb = ^branch_target[1:0];
        if_valid         = !rst && (r_count != '0);
        if_instr         = r_buf_instr[r_rd_ptr];
        if_pc            = r_buf_pc[r_rd_ptr];
        if_opcode        = if_instr[31:26];
        // A redirect withdraws a request memory is not taking this cycle; if ready is high
        // the old-address request still goes out and its response is dropped later.
        imem_req         = !rst && (r_state == StReq) && w_has_space
                           && (!branch_taken || imem_ready);
        imem_addr        = r_pc;
        w_issue          = imem_req && imem_ready;
        w_push           = !branch_taken && (r_state == StWait) && imem_rvalid;
        w_pop            = if_valid && !id_stall && !branch_taken;
    end

    // Fetch FSM, PC and FIFO pointers/occupancy; a redirect overrides every other event.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= StReq;
            r_pc     <= RESET_PC;
            r_req_pc <= RESET_PC;
            r_count  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (branch_taken) begin
            r_pc     <= {branch_target[31:2], 2'b00};
            r_count  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            unique case (r_state)
                StReq:   r_state <= w_issue ? StDrop : StReq;
                // A response landing in the redirect cycle is consumed and discarded here.
                StWait:  r_state <= imem_rvalid ? StReq : StDrop;
                StDrop:  r_state <= imem_rvalid ? StReq : StDrop;
                default: r_state <= StReq;
            endcase
        end else begin
            unique case (r_state)
                StReq: begin
                    if (w_issue) begin
                        r_req_pc <= r_pc;
                        r_state  <= StWait;
                    end
                end
                StWait: begin
                    if (imem_rvalid) begin
                        r_pc    <= r_pc + 32'd4;
                        r_state <= StReq;
                    end
                end
                StDrop: begin
                    if (imem_rvalid) begin
                        r_state <= StReq;
                    end
                end
                default: r_state <= StReq;
            endcase
            // Depth is a power of two, so pointers wrap naturally.
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PtrW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PtrW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CntW'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CntW'(1);
            end
        end
    end

    // FIFO storage; entries are only observed once counted, so no reset is needed.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_buf_instr[r_wr_ptr] <= imem_rdata;
            r_buf_pc[r_wr_ptr]    <= r_req_pc;
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: vector table for reset/streaming (plus a wrapping-PC instance),
// directed backpressure and redirect sequences, and random traffic against a queue model.
module tb_instr_fetch_unit;

    localparam int Depth = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_ready = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = 32'h0;
    logic        id_stall = 1'b0;

    logic        imem_req, if_valid;
    logic [31:0] imem_addr, if_instr, if_pc;
    logic [5:0]  if_opcode;
    logic        w_req, w_valid;
    logic [31:0] w_addr, w_instr, w_pc;
    logic [5:0]  w_opcode;

    instr_fetch_unit #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(Depth)) u_dut (
        .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .branch_taken(branch_taken), .branch_target(branch_target), .id_stall(id_stall),
        .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .if_opcode(if_opcode)
    );

    instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .BUF_DEPTH(Depth)) u_wrap (
        .clk(clk), .rst(rst), .imem_req(w_req), .imem_addr(w_addr),
        .imem_ready(imem_ready), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .branch_taken(branch_taken), .branch_target(branch_target), .id_stall(id_stall),
        .if_valid(w_valid), .if_instr(w_instr), .if_pc(w_pc), .if_opcode(w_opcode)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: fetched-but-undelivered words as a queue, plus one outstanding slot.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    entry_t      mq[$];
    logic [31:0] m_pc = 32'h0;
    logic [31:0] m_req_pc = 32'h0;
    bit          m_outst = 1'b0;
    bit          m_stale = 1'b0;
    bit          exp_req = 1'b0;

    // Memory model.
    bit          mem_busy = 1'b0;
    logic [31:0] mem_addr = 32'h0;
    int          mem_wait = 0;
    int          mem_lat = 1;
    bit          mem_rdy_always = 1'b1;

    // Snapshot of DUT outputs from the last cycle() call.
    logic        s_req, s_valid;
    logic [31:0] s_addr, s_pc, s_instr;

    function automatic logic [31:0] memword(input logic [31:0] a);
        return (a == 32'h0000_000C) ? 32'h8C01_0004 : (a ^ 32'hA5A5_0000);
    endfunction

    task automatic model_edge();
        bit issue;
        bit resp;
        issue = exp_req && imem_ready;
        resp  = m_outst && imem_rvalid;
        if (rst) begin
            m_pc = 32'h0;
            mq.delete();
            m_outst = 1'b0;
            m_stale = 1'b0;
        end else if (branch_taken) begin
            mq.delete();
            m_pc = branch_target & 32'hFFFF_FFFC;
            if (issue) begin
                m_outst = 1'b1;
                m_stale = 1'b1;
            end else if (resp) begin
                m_outst = 1'b0;
            end else if (m_outst) begin
                m_stale = 1'b1;
            end
        end else begin
            if (mq.size() != 0 && !id_stall) void'(mq.pop_front());
            if (resp) begin
                m_outst = 1'b0;
                if (!m_stale) begin
                    mq.push_back({m_req_pc, imem_rdata});
                    m_pc = m_pc + 32'd4;
                end
            end
            if (issue) begin
                m_outst  = 1'b1;
                m_stale  = 1'b0;
                m_req_pc = m_pc;
            end
        end
    endtask

    task automatic mem_edge();
        if (rst) begin
            mem_busy = 1'b0;
        end else begin
            if (mem_busy && imem_rvalid) mem_busy = 1'b0;
            else if (mem_busy && mem_wait > 0) mem_wait--;
            if (s_req && imem_ready) begin
                mem_busy = 1'b1;
                mem_addr = s_addr;
                mem_wait = ((mem_lat == 0) ? int'($urandom_range(3, 1)) : mem_lat) - 1;
            end
        end
    endtask

    // One clock: memory drives its inputs, outputs are checked against the model, then the edge.
    task automatic cycle();
        bit ev;
        imem_ready  = mem_rdy_always ? 1'b1 : ($urandom_range(3) != 0);
        imem_rvalid = mem_busy && (mem_wait == 0);
        imem_rdata  = imem_rvalid ? memword(mem_addr) : $urandom;
        #1;
        exp_req = !rst && !m_outst && (mq.size() < Depth) && (!branch_taken || imem_ready);
        ev      = !rst && (mq.size() != 0);
        s_req = imem_req; s_addr = imem_addr; s_valid = if_valid; s_pc = if_pc; s_instr = if_instr;
        chk("req", 32'(imem_req), 32'(exp_req));
        if (exp_req) chk("addr", imem_addr, m_pc);
        chk("valid", 32'(if_valid), 32'(ev));
        if (ev) begin
            chk("if_pc", if_pc, mq[0].pc);
            chk("if_instr", if_instr, mq[0].instr);
            chk("if_opcode", 32'(if_opcode), 32'(mq[0].instr[31:26]));
        end
        @(posedge clk);
        model_edge();
        mem_edge();
        @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        branch_taken = 1'b0;
        id_stall = 1'b0;
        repeat (n) cycle();
        rst = 1'b0;
    endtask

    typedef struct {
        bit          rst;
        bit          ready;
        bit          rvalid;
        logic [31:0] rdata;
        bit          e_req;
        logic [31:0] e_addr;
        bit          e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        logic [5:0]  e_op;
    } vec_t;

    function automatic vec_t mk(bit r, bit rdy, bit rv, logic [31:0] rd, bit er, logic [31:0] ea,
                                bit ev, logic [31:0] ep, logic [31:0] ei, logic [5:0] eo);
        vec_t v;
        v.rst = r; v.ready = rdy; v.rvalid = rv; v.rdata = rd;
        v.e_req = er; v.e_addr = ea; v.e_valid = ev; v.e_pc = ep; v.e_instr = ei; v.e_op = eo;
        return v;
    endfunction

    vec_t tbl[12];
    int   got[$];
    bit   found;

    initial begin
        // Reset for 3 cycles, then zero-wait memory with no stall.
        tbl[0]  = mk(1, 0, 0, 32'hDEAD_BEEF, 0, 32'h0,  0, 32'h0, 32'h0, 6'h0);
        tbl[1]  = mk(1, 0, 0, 32'hDEAD_BEEF, 0, 32'h0,  0, 32'h0, 32'h0, 6'h0);
        tbl[2]  = mk(1, 0, 0, 32'hDEAD_BEEF, 0, 32'h0,  0, 32'h0, 32'h0, 6'h0);
        tbl[3]  = mk(0, 1, 0, 32'hDEAD_BEEF, 1, 32'h0,  0, 32'h0, 32'h0, 6'h0);
        tbl[4]  = mk(0, 1, 1, 32'hA5A5_0000, 0, 32'h0,  0, 32'h0, 32'h0, 6'h0);
        tbl[5]  = mk(0, 1, 0, 32'hDEAD_BEEF, 1, 32'h4,  1, 32'h0, 32'hA5A5_0000, 6'b101001);
        tbl[6]  = mk(0, 1, 1, 32'hA5A5_0004, 0, 32'h0,  0, 32'h0, 32'h0, 6'h0);
        tbl[7]  = mk(0, 1, 0, 32'hDEAD_BEEF, 1, 32'h8,  1, 32'h4, 32'hA5A5_0004, 6'b101001);
        tbl[8]  = mk(0, 1, 1, 32'hA5A5_0008, 0, 32'h0,  0, 32'h0, 32'h0, 6'h0);
        tbl[9]  = mk(0, 1, 0, 32'hDEAD_BEEF, 1, 32'hC,  1, 32'h8, 32'hA5A5_0008, 6'b101001);
        tbl[10] = mk(0, 1, 1, 32'h8C01_0004, 0, 32'h0,  0, 32'h0, 32'h0, 6'h0);
        tbl[11] = mk(0, 0, 0, 32'hDEAD_BEEF, 1, 32'h10, 1, 32'hC, 32'h8C01_0004, 6'b100011);

        foreach (tbl[i]) begin
            rst = tbl[i].rst; imem_ready = tbl[i].ready; imem_rvalid = tbl[i].rvalid;
            imem_rdata = tbl[i].rdata; branch_taken = 1'b0; id_stall = 1'b0;
            #1;
            chk($sformatf("t%0d_req", i), 32'(imem_req), 32'(tbl[i].e_req));
            chk($sformatf("t%0d_wrap_req", i), 32'(w_req), 32'(tbl[i].e_req));
            if (tbl[i].e_req) begin
                chk($sformatf("t%0d_addr", i), imem_addr, tbl[i].e_addr);
                chk($sformatf("t%0d_wrap_addr", i), w_addr, tbl[i].e_addr + 32'hFFFF_FFFC);
            end
            chk($sformatf("t%0d_valid", i), 32'(if_valid), 32'(tbl[i].e_valid));
            chk($sformatf("t%0d_wrap_valid", i), 32'(w_valid), 32'(tbl[i].e_valid));
            if (tbl[i].e_valid) begin
                chk($sformatf("t%0d_pc", i), if_pc, tbl[i].e_pc);
                chk($sformatf("t%0d_instr", i), if_instr, tbl[i].e_instr);
                chk($sformatf("t%0d_opcode", i), 32'(if_opcode), 32'(tbl[i].e_op));
                chk($sformatf("t%0d_wrap_pc", i), w_pc, tbl[i].e_pc + 32'hFFFF_FFFC);
            end
            @(posedge clk);
            @(negedge clk);
        end

        // Backpressure: stall for 10 cycles, then drain.
        mem_rdy_always = 1'b1; mem_lat = 1;
        do_reset(3);
        id_stall = 1'b1;
        repeat (10) cycle();
        chk("bp_req_low", 32'(s_req), 32'h0);
        chk("bp_valid", 32'(s_valid), 32'h1);
        chk("bp_hold_pc", s_pc, 32'h0);
        id_stall = 1'b0;
        got.delete();
        repeat (12) begin
            cycle();
            if (s_valid) got.push_back(int'(s_pc));
        end
        chk("bp_delivered_ge3", 32'(got.size() >= 3), 32'h1);
        foreach (got[i]) chk($sformatf("bp_seq%0d", i), 32'(got[i]), 32'(4 * i));

        // Redirect while waiting: slow memory, branch one cycle after issue.
        mem_lat = 3;
        do_reset(2);
        cycle();
        chk("rw_first_issue", s_addr, 32'h0);
        branch_taken = 1'b1; branch_target = 32'h0000_0100;
        cycle();
        branch_taken = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            cycle();
            if (s_valid) chk("rw_stale_visible", s_pc, 32'h100);
            if (s_req) begin
                found = 1'b1;
                chk("rw_next_addr", s_addr, 32'h100);
            end
        end
        chk("rw_req_seen", 32'(found), 32'h1);
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            cycle();
            if (s_valid) begin
                found = 1'b1;
                chk("rw_next_if_pc", s_pc, 32'h100);
            end
        end
        chk("rw_valid_seen", 32'(found), 32'h1);

        // Redirect coincident with rvalid, unaligned target.
        mem_lat = 1;
        do_reset(2);
        cycle();
        branch_taken = 1'b1; branch_target = 32'h0000_0203;
        cycle();
        branch_taken = 1'b0;
        cycle();
        chk("rc_req", 32'(s_req), 32'h1);
        chk("rc_addr", s_addr, 32'h200);
        chk("rc_empty", 32'(s_valid), 32'h0);
        repeat (3) cycle();

        // Random traffic against the model.
        mem_rdy_always = 1'b0; mem_lat = 0;
        do_reset(2);
        for (int n = 0; n < 4000; n++) begin
            rst           = ($urandom_range(199) == 0);
            id_stall      = ($urandom_range(9) < 3);
            branch_taken  = ($urandom_range(19) == 0);
            branch_target = $urandom;
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
